// File: rtl/axi_wr_burst_master.sv
// axi_wr_burst_master: write-side AXI4 master. Turns burst/tail requests from the
// FIFO status controller into INCR write bursts (split at MAX_BEATS), streams
// data from an FWFT line FIFO, and returns resp/done handshakes.
// Ports:
//   clock, rst_n                  clock, async active-low reset
//   burst_req, tail_req, req_len  level requests and their beat count
//   resp, done                    1-cycle pulses: accepted / fully written
//   rst_chain                     abort from controller
//   frame_start, frame_base       reload of the write address pointer
//   fifo_dout, fifo_empty, fifo_rd_en   FWFT FIFO read side
//   m_aw*, m_w*, m_b*             AXI4 write address/data/response channels
//   bresp_err                     sticky non-OKAY response flag
//   busy                          high whenever the FSM is not idle
module axi_wr_burst_master #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned AXI_ID    = 0,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  burst_req,
    input  logic                  tail_req,
    input  logic [LSIZE-1:0]      req_len,
    output logic                  resp,
    output logic                  done,
    input  logic                  rst_chain,
    input  logic                  frame_start,
    input  logic [ADDR_W-1:0]     frame_base,
    input  logic [DATA_W-1:0]     fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [3:0]            m_awid,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic                  bresp_err,
    output logic                  busy
);
    localparam int unsigned SIZE_LOG2 = $clog2(DATA_W / 8);
    localparam int unsigned MB_W      = $clog2(MAX_BEATS + 1);
    localparam int unsigned CNT_W     = (LSIZE > MB_W) ? LSIZE : MB_W;
    localparam logic [CNT_W-1:0] MAX_BEATS_C = CNT_W'(MAX_BEATS);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BWAIT, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [LSIZE-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]         awlen_q, awlen_d;
    logic               awvalid_q, awvalid_d;
    logic               bready_q, bready_d;
    logic               busy_q, busy_d;
    logic               resp_q, resp_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               resp_pend_q, resp_pend_d;
    logic               abort_q, abort_d;
    logic               fs_pend_q, fs_pend_d;
    logic               load_aw;

    logic in_data, aw_hs, w_hs, b_hs;

    // W channel is driven straight from the FWFT head; an abort drains with null strobes
    assign in_data    = (state_q == S_DATA);
    assign m_wvalid   = in_data & (abort_q | ~fifo_empty);
    assign m_wdata    = fifo_dout;
    assign m_wstrb    = abort_q ? '0 : '1;
    assign m_wlast    = in_data & (beat_cnt_q == awlen_q);
    assign fifo_rd_en = in_data & ~abort_q & ~fifo_empty & m_wready;

    assign aw_hs = awvalid_q & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = bready_q & m_bvalid;

    assign m_awaddr  = ptr_q;
    assign m_awlen   = awlen_q;
    assign m_awid    = 4'(AXI_ID);
    assign m_awsize  = 3'(SIZE_LOG2);
    assign m_awburst = 2'b01;
    assign m_awvalid = awvalid_q;
    assign m_bready  = bready_q;
    assign resp      = resp_q;
    assign done      = done_q;
    assign bresp_err = err_q;
    assign busy      = busy_q;

    // State and datapath registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            ptr_q       <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            awlen_q     <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            resp_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            resp_pend_q <= 1'b0;
            abort_q     <= 1'b0;
            fs_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            awlen_q     <= awlen_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
            busy_q      <= busy_d;
            resp_q      <= resp_d;
            done_q      <= done_d;
            err_q       <= err_d;
            resp_pend_q <= resp_pend_d;
            abort_q     <= abort_d;
            fs_pend_q   <= fs_pend_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        awlen_d     = awlen_q;
        resp_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        resp_pend_d = resp_pend_q;
        abort_d     = abort_q;
        fs_pend_d   = fs_pend_q;
        load_aw     = 1'b0;

        // A frame reload seen while busy waits for the return to idle
        if (frame_start && (state_q != S_IDLE)) begin
            fs_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (frame_start || fs_pend_q) begin
                    ptr_d     = frame_base;
                    err_d     = 1'b0;
                    fs_pend_d = 1'b0;
                end
                // Both request kinds carry the same length, so tail priority is implicit
                if (tail_req || burst_req) begin
                    remaining_d = req_len;
                    if (req_len == '0) begin
                        resp_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        resp_pend_d = 1'b1;
                        load_aw     = 1'b1;
                        state_d     = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (rst_chain) abort_d = 1'b1;
                if (aw_hs) begin
                    beat_cnt_d = '0;
                    state_d    = S_DATA;
                    if (resp_pend_q) begin
                        resp_d      = 1'b1;
                        resp_pend_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (rst_chain) abort_d = 1'b1;
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (m_wlast) begin
                        state_d = S_BWAIT;
                        if (!abort_q) begin
                            ptr_d       = ptr_q + (ADDR_W'(beats_q) << SIZE_LOG2);
                            remaining_d = remaining_q - LSIZE'(beats_q);
                        end
                    end
                end
            end
            S_BWAIT: begin
                if (rst_chain) abort_d = 1'b1;
                if (b_hs) begin
                    if (m_bresp != 2'b00) err_d = 1'b1;
                    if (abort_q || rst_chain) begin
                        state_d = S_IDLE;
                    end else if (remaining_q != '0) begin
                        load_aw = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Size the next sub-burst from what is left of the request
        if (load_aw) begin
            beats_d = (CNT_W'(remaining_d) > MAX_BEATS_C) ? MAX_BEATS_C : CNT_W'(remaining_d);
            awlen_d = 8'(beats_d - CNT_W'(1));
        end

        awvalid_d = (state_d == S_ADDR);
        bready_d  = (state_d == S_BWAIT);
        busy_d    = (state_d != S_IDLE);
    end
endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Directed bench for axi_wr_burst_master: a table of requests with hand-computed
// AW/W/B expectations, plus hand-built abort, frame-reload and reset sequences.
module tb_axi_wr_burst_master;
    localparam int unsigned BUDGET = 4000;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        burst_req, tail_req;
    logic [8:0]  req_len;
    logic        resp, done, rst_chain, frame_start;
    logic [31:0] frame_base;
    logic [63:0] fifo_dout;
    logic        fifo_empty, fifo_rd_en;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [3:0]  m_awid;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid, m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready, bresp_err, busy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] fifo_q[$];

    always #5 clock = ~clock;

    axi_wr_burst_master dut (
        .clock(clock), .rst_n(rst_n), .burst_req(burst_req), .tail_req(tail_req),
        .req_len(req_len), .resp(resp), .done(done), .rst_chain(rst_chain),
        .frame_start(frame_start), .frame_base(frame_base), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awid(m_awid), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .bresp_err(bresp_err), .busy(busy)
    );

    typedef struct {
        bit          tail;
        int          len;
        bit          gaps;
        logic [1:0]  bresp;
        int          fs_cyc;      // cycle of a frame_start pulse while busy (0 = none)
        bit          fs_req;      // frame_start together with the request
        logic [31:0] fs_base;
        int          abort_beat;  // rst_chain during this data beat (0 = none)
        int          naw;
        int          l0, l1;
        logic [31:0] a0, a1;
        int          pops;
        int          zero_beats;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(bit tail, int len, bit gaps, logic [1:0] br, int fs_cyc,
                                logic [31:0] fs_base, int naw, int l0, int l1,
                                logic [31:0] a0, logic [31:0] a1, int pops, bit dn, bit err);
        vec_t v;
        v.tail = tail; v.len = len; v.gaps = gaps; v.bresp = br; v.fs_cyc = fs_cyc;
        v.fs_req = 1'b0; v.fs_base = fs_base; v.abort_beat = 0; v.naw = naw;
        v.l0 = l0; v.l1 = l1; v.a0 = a0; v.a1 = a1; v.pops = pops; v.zero_beats = 0;
        v.exp_done = dn; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input string tag);
        int aw_cnt = 0, aw_first = -1, awhs_cyc = -1;
        int resp_cnt = 0, resp_cyc = -1, done_cnt = 0, done_cyc = -1;
        int pops = 0, strb_beats = 0, zero_beats = 0, bad = 0;
        int beat = 0, cur_len = 0, bpend = 0, idle_cnt = 0;
        int awl0 = -1, awl1 = -1;
        bit pop_pend = 0, aw_prev = 0, fin = 0, gap;
        logic [31:0] addr0 = '0, addr1 = '0;
        logic [63:0] exp_data;

        fifo_q.delete();
        for (int i = 0; i < v.len; i++) fifo_q.push_back({32'hCAFE0000 + 32'(v.len), 32'(i)});
        exp_data = {32'hCAFE0000 + 32'(v.len), 32'd0};

        for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
            @(negedge clock);
            if (pop_pend) begin
                void'(fifo_q.pop_front());
                pop_pend = 0;
            end
            burst_req   = (cyc == 0) && !v.tail;
            tail_req    = (cyc == 0) && v.tail;
            req_len     = (cyc == 0) ? 9'(v.len) : 9'd0;
            frame_start = (cyc == 0 && v.fs_req) || (v.fs_cyc != 0 && cyc == v.fs_cyc);
            if (frame_start) frame_base = v.fs_base;
            rst_chain   = 1'b0;
            m_awready   = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready    = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            gap         = v.gaps && ($urandom_range(0, 3) == 0);
            fifo_empty  = (fifo_q.size() == 0) || gap;
            fifo_dout   = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
            m_bvalid    = (bpend > 0);
            m_bresp     = v.bresp;
            #1;
            if (aw_prev && !m_awvalid) bad++;
            aw_prev = m_awvalid && !m_awready;
            if (resp) begin resp_cnt++; resp_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (m_awvalid && aw_first < 0) aw_first = cyc;
            if (m_awvalid && m_awready) begin
                aw_cnt++;
                if (aw_cnt == 1) begin
                    addr0 = m_awaddr; awl0 = int'(m_awlen); awhs_cyc = cyc; cur_len = v.l0;
                end else begin
                    if (aw_cnt == 2) begin addr1 = m_awaddr; awl1 = int'(m_awlen); end
                    cur_len = v.l1;
                end
                beat = 0;
                if (m_awsize != 3'd3 || m_awburst != 2'b01 || m_awid != 4'd0) bad++;
            end
            if (m_wvalid && m_wready) begin
                beat++;
                if (m_wlast != (beat == cur_len + 1)) bad++;
                if (m_wlast) bpend++;
                if (m_wstrb == 8'hFF) begin
                    strb_beats++;
                    if (m_wdata != exp_data) bad++;
                    exp_data++;
                    if (v.abort_beat != 0 && strb_beats == v.abort_beat) rst_chain = 1'b1;
                end else if (m_wstrb == 8'h00) begin
                    zero_beats++;
                end else begin
                    bad++;
                end
            end
            if (fifo_rd_en) begin
                pops++;
                pop_pend = 1;
                if (!(m_wvalid && m_wready && m_wstrb == 8'hFF)) bad++;
            end
            if (m_wvalid && fifo_empty && m_wstrb != 8'h00) bad++;
            if (m_bvalid && m_bready) bpend--;
            if (resp_cnt > 0 && !busy) idle_cnt++;
            if (idle_cnt >= 3) fin = 1;
        end
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; frame_start = 1'b0;
        rst_chain = 1'b0; fifo_empty = 1'b1;

        chk({tag, " finished"}, 64'(fin), 64'd1);
        chk({tag, " aw_count"}, 64'(aw_cnt), 64'(v.naw));
        if (v.naw > 0) begin
            chk({tag, " awaddr0"}, 64'(addr0), 64'(v.a0));
            chk({tag, " awlen0"}, 64'(awl0), 64'(v.l0));
            chk({tag, " aw_latency"}, 64'(aw_first), 64'd1);
            chk({tag, " resp_after_aw"}, 64'(resp_cyc - awhs_cyc), 64'd1);
        end else begin
            chk({tag, " no_awvalid"}, 64'(aw_first + 1), 64'd0);
            chk({tag, " done_after_resp"}, 64'(done_cyc - resp_cyc), 64'd1);
        end
        if (v.naw > 1) begin
            chk({tag, " awaddr1"}, 64'(addr1), 64'(v.a1));
            chk({tag, " awlen1"}, 64'(awl1), 64'(v.l1));
        end
        chk({tag, " resp_count"}, 64'(resp_cnt), 64'd1);
        chk({tag, " done_count"}, 64'(done_cnt), 64'(v.exp_done));
        chk({tag, " pops"}, 64'(pops), 64'(v.pops));
        chk({tag, " data_beats"}, 64'(strb_beats), 64'(v.pops));
        chk({tag, " null_beats"}, 64'(zero_beats), 64'(v.zero_beats));
        chk({tag, " protocol_errors"}, 64'(bad), 64'd0);
        chk({tag, " bresp_err"}, 64'(bresp_err), 64'(v.exp_err));
        chk({tag, " busy_end"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[11];
    vec_t hv;

    initial begin
        rst_n = 1'b0; burst_req = 0; tail_req = 0; req_len = '0; rst_chain = 0;
        frame_start = 0; frame_base = '0; fifo_dout = '0; fifo_empty = 1'b1;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;

        //            tail len  gaps bresp fs  fs_base    naw l0   l1  a0          a1          pops done err
        vecs[0]  = mk(0, 100, 0, 2'b00, 0, 32'h0,    1,  99,  0, 32'h1000, 32'h0,    100, 1, 0);
        vecs[1]  = mk(0,   1, 0, 2'b00, 0, 32'h0,    1,   0,  0, 32'h1320, 32'h0,      1, 1, 0);
        vecs[2]  = mk(1, 300, 0, 2'b00, 0, 32'h0,    2, 255, 43, 32'h1328, 32'h1B28, 300, 1, 0);
        vecs[3]  = mk(0,  37, 1, 2'b00, 0, 32'h0,    1,  36,  0, 32'h1C88, 32'h0,     37, 1, 0);
        vecs[4]  = mk(1,   0, 0, 2'b00, 0, 32'h0,    0,   0,  0, 32'h0,    32'h0,      0, 1, 0);
        vecs[5]  = mk(0, 256, 1, 2'b00, 0, 32'h0,    1, 255,  0, 32'h1DB0, 32'h0,    256, 1, 0);
        vecs[6]  = mk(0, 257, 0, 2'b00, 0, 32'h0,    2, 255,  0, 32'h25B0, 32'h2DB0, 257, 1, 0);
        vecs[7]  = mk(0,  20, 1, 2'b10, 0, 32'h0,    1,  19,  0, 32'h2DB8, 32'h0,     20, 1, 1);
        vecs[8]  = mk(0,   4, 0, 2'b00, 0, 32'h0,    1,   3,  0, 32'h2E58, 32'h0,      4, 1, 1);
        vecs[9]  = mk(0, 260, 0, 2'b00, 3, 32'h8000, 2, 255,  3, 32'h2E78, 32'h3678, 260, 1, 0);
        vecs[10] = mk(1,   2, 0, 2'b00, 0, 32'h0,    1,   1,  0, 32'h8000, 32'h0,      2, 1, 0);

        repeat (3) @(negedge clock);
        #1;
        chk("reset_outputs",
            64'({resp, done, m_awvalid, m_wvalid, fifo_rd_en, m_bready, bresp_err, busy}), 64'd0);
        chk("reset_pointer", 64'(m_awaddr), 64'd0);
        @(negedge clock);
        rst_n = 1'b1;

        // Standalone reload of the pointer in idle
        @(negedge clock);
        frame_base = 32'h1000; frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        #1;
        chk("frame_reload_idle", 64'(m_awaddr), 64'h1000);

        for (int i = 0; i < 11; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // Reload and request in the same idle cycle: new base must be used
        hv = mk(0, 3, 0, 2'b00, 0, 32'hA000, 1, 2, 0, 32'hA000, 32'h0, 3, 1, 0);
        hv.fs_req = 1'b1;
        run_req(hv, "fs_with_req");

        // Abort during beat 10 of 100: remaining 90 beats drain with null strobes
        hv = mk(0, 100, 0, 2'b00, 0, 32'h0, 1, 99, 0, 32'hA018, 32'h0, 10, 0, 0);
        hv.abort_beat = 10;
        hv.zero_beats = 90;
        run_req(hv, "abort");

        // Pointer is not advanced by the aborted burst
        hv = mk(0, 5, 0, 2'b00, 0, 32'h0, 1, 4, 0, 32'hA018, 32'h0, 5, 1, 0);
        run_req(hv, "post_abort");

        // Asynchronous reset in the middle of a burst
        @(negedge clock);
        burst_req = 1'b1; req_len = 9'd50; fifo_empty = 1'b0; fifo_dout = 64'h55;
        m_awready = 1'b1; m_wready = 1'b1;
        @(negedge clock);
        burst_req = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        chk("busy_before_reset", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({resp, done, m_awvalid, m_wvalid, fifo_rd_en, m_bready, bresp_err, busy}), 64'd0);
        chk("async_reset_pointer", 64'(m_awaddr), 64'd0);
        m_awready = 1'b0; m_wready = 1'b0; fifo_empty = 1'b1;
        @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_wr_burst_master.md
Name: axi_wr_burst_master

Overview:
- Write-side AXI4 master, directly downstream of the FIFO status controller.
- Consumes burst/tail requests and their lengths, and issues AXI4 INCR write bursts to frame memory.
- Pops write data from a first-word-fall-through (FWFT) line FIFO.
- Returns the resp (request accepted) and done (write complete) handshakes that the controller waits on.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 64, AXI/FIFO data width (power of 2, >=8)
LSIZE, 9, request length width in beats
AXI_ID, 0, constant awid value
MAX_BEATS, 256, largest single AXI burst; longer requests are split

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
burst_req  in  1  level request for a full burst
tail_req  in  1  level request for a tail burst
req_len  in  LSIZE  beats requested; valid while burst_req or tail_req is high
resp  out  1  one-cycle pulse: request accepted
done  out  1  one-cycle pulse: all beats written and all B responses received
rst_chain  in  1  abort from controller
frame_start  in  1  pulse: reload address pointer
frame_base  in  ADDR_W  frame base byte address
fifo_dout  in  DATA_W  FWFT FIFO data
fifo_empty  in  1  FIFO empty
fifo_rd_en  out  1  FIFO pop
m_awaddr/awlen/awid/awsize/awburst/awvalid  out  ADDR_W/8/4/3/2/1  AXI AW channel
m_awready  in  1
m_wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  AXI W channel
m_wready  in  1
m_bresp/bvalid  in  2/1  AXI B channel
m_bready  out  1
bresp_err  out  1  sticky error flag; cleared by frame_start
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all valids, resp, done, fifo_rd_en, bresp_err, busy = 0; address pointer = 0; state = IDLE.
- Fixed AXI fields: awburst = INCR; awsize = log2(DATA_W/8); awid = AXI_ID.
- States: IDLE, ADDR, DATA, BWAIT, FIN.
- IDLE:
  - tail_req has priority over burst_req.
  - On a request: latch remaining = req_len. If req_len == 0, pulse resp, go to FIN (no AXI traffic). Otherwise go to ADDR.
- ADDR:
  - awlen = min(remaining, MAX_BEATS) - 1; awaddr = pointer.
  - awvalid held until awready.
  - On the first AW handshake of a request, pulse resp (registered, 1 cycle after the handshake).
  - On handshake, go to DATA.
- DATA:
  - wvalid = !fifo_empty; wdata = fifo_dout; wstrb all ones.
  - fifo_rd_en = wvalid & wready, combinational.
  - wlast on the final beat of the sub-burst.
  - On the wlast handshake: pointer += beats*DATA_W/8 (wraps modulo 2^ADDR_W); remaining -= beats; go to BWAIT.
- BWAIT:
  - bready = 1.
  - On bvalid: if bresp != OKAY, set bresp_err.
  - Then go to ADDR if remaining != 0, else FIN.
- FIN: pulse done for 1 cycle, return to IDLE.
- Minimum latency from request to awvalid: 1 cycle.
- Exactly one resp and one done per accepted request, including split requests.
- Requests are sampled only in IDLE; req_len is not re-read mid-transfer.
- 4 KB boundary: not split by this block. Frame base is 4 KB aligned and BURST_LEN*DATA_W/8 divides 4096; the integration guarantees this.
- frame_start:
  - In IDLE: pointer <= frame_base and bresp_err cleared, next cycle.
  - While busy: latched and applied on return to IDLE.
  - Simultaneous frame_start and request in IDLE: the pointer reload takes effect before that request's awaddr.
- rst_chain (abort):
  - AXI handshakes are never withdrawn.
  - In ADDR: complete the AW handshake, then send all remaining beats of that sub-burst with wstrb = 0 and wvalid = 1 with no FIFO pops, then wait for B, then go to IDLE.
  - In DATA: remaining beats are sent the same way (wstrb = 0, no pops).
  - No further sub-bursts are issued; done is not pulsed; pointer is unchanged.
  - In IDLE/FIN: ignored.
- Async reset mid-burst: immediate return to reset values. The system holds the AXI interconnect in reset at the same time.

Test Plan:
- Single burst: frame_base = 0x1000, burst_req with req_len = 100, FIFO full → awaddr = 0x1000, awlen = 99, resp 1 cycle after AW handshake, 100 pops, wlast on beat 100, done after B; next request awaddr = 0x1320 (DATA_W = 64).
- Split: tail_req with req_len = 300 → two AW handshakes with awlen = 255 then 43, one resp, one done, 300 pops, address advances 2400 bytes.
- Backpressure: random wready and fifo_empty gaps → no pop without a W handshake, wdata order matches the FIFO, wvalid never high while empty.
- Zero length: req_len = 0 → resp then done 1 cycle apart, no awvalid.
- Error and frame reload: bresp = SLVERR on a burst → bresp_err = 1 and done still pulses; frame_start while busy → pointer = frame_base only after return to IDLE, and bresp_err cleared then.
- Abort: rst_chain during beat 10 of 100 → beats 11–100 sent with wstrb = 0 and no pops, wlast correct, B accepted, IDLE, no done.
